// File: rtl/sha256_core.sv
// ============================================================================
//  Module      : sha256_core
//  Description : Single-block SHA-256 compression engine. Hashes one
//                pre-padded 512-bit block from the standard initial hash
//                values at one round per clock. The digest appears 65 cycles
//                after the start edge and is flagged by ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block_in,
    output logic [255:0] hash_out,
    output logic         ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [31:0] c_iv [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] c_k [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    state_t      r_state;
    logic [5:0]  r_t;
    logic [31:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    // Sliding schedule window: for t<16 it holds W[t..t+15] (rotating the
    // block in), for t>=16 it holds W[t-16..t-1].
    logic [31:0] r_w [16];

    logic [31:0] w_wt;
    logic [31:0] w_t1;
    logic [31:0] w_t2;

    // Message schedule word and round temporaries for the current round
    always_comb begin
        w_wt = r_w[0];
        if (r_t >= 6'd16) begin
            w_wt = small_s1(r_w[14]) + r_w[9] + small_s0(r_w[1]) + r_w[0];
        end
        w_t1 = r_h + big_s1(r_e) + ((r_e & r_f) ^ (~r_e & r_g)) + c_k[r_t] + w_wt;
        w_t2 = big_s0(r_a) + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));
    end

    // Control FSM, round datapath, schedule window and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_t      <= 6'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_c      <= 32'd0;
            r_d      <= 32'd0;
            r_e      <= 32'd0;
            r_f      <= 32'd0;
            r_g      <= 32'd0;
            r_h      <= 32'd0;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= 32'd0;
            end
            hash_out <= 256'd0;
            ready    <= 1'b0;
        end else begin
            case (r_state)
                ROUND: begin
                    r_h <= r_g;
                    r_g <= r_f;
                    r_f <= r_e;
                    r_e <= r_d + w_t1;
                    r_d <= r_c;
                    r_c <= r_b;
                    r_b <= r_a;
                    r_a <= w_t1 + w_t2;
                    for (int i = 0; i < 15; i++) begin
                        r_w[i] <= r_w[i+1];
                    end
                    r_w[15] <= w_wt;
                    r_t     <= r_t + 6'd1;
                    if (r_t == 6'd63) begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= block_in[511 - 32*i -: 32];
                        end
                        r_a     <= c_iv[0];
                        r_b     <= c_iv[1];
                        r_c     <= c_iv[2];
                        r_d     <= c_iv[3];
                        r_e     <= c_iv[4];
                        r_f     <= c_iv[5];
                        r_g     <= c_iv[6];
                        r_h     <= c_iv[7];
                        r_t     <= 6'd0;
                        ready   <= 1'b0;
                        r_state <= ROUND;
                    end else if (r_state == DONE && !ready) begin
                        // First cycle in DONE: fold the working state into the IV
                        hash_out <= {c_iv[0] + r_a, c_iv[1] + r_b,
                                     c_iv[2] + r_c, c_iv[3] + r_d,
                                     c_iv[4] + r_e, c_iv[5] + r_f,
                                     c_iv[6] + r_g, c_iv[7] + r_h};
                        ready    <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha256_core.sv
// ============================================================================
//  Module      : tb_sha256_core
//  Description : Directed self-checking bench for sha256_core using the
//                "abc" and empty-message single-block vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha256_core;

    logic         clk;
    logic         rst;
    logic         start;
    logic [511:0] block_in;
    logic [255:0] hash_out;
    logic         ready;

    int checks = 0;
    int errors = 0;

    localparam logic [511:0] c_blk_abc   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] c_blk_empty = {32'h80000000, 480'h0};
    localparam logic [255:0] c_dig_abc   =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_dig_empty =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    sha256_core dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .block_in (block_in),
        .hash_out (hash_out),
        .ready    (ready)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive start for exactly one rising edge (edge N); returns #1 after edge N
    task automatic pulse_start(input logic [511:0] blk);
        @(negedge clk);
        block_in = blk;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        block_in = '0;
    endtask

    // From #1 after edge N: ready must stay low through edge N+64, rise at N+65
    task automatic finish_block(input string tag, input logic [255:0] exp);
        int high_seen;
        high_seen = 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) high_seen++;
        end
        check({tag, "_ready_low_rounds"}, 256'(high_seen), 256'd0);
        @(posedge clk);
        #1;
        check({tag, "_ready_at_65"}, {255'd0, ready}, 256'd1);
        check({tag, "_digest"}, hash_out, exp);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        block_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("reset_ready", {255'd0, ready}, 256'd0);
        check("reset_hash", hash_out, 256'd0);
        repeat (2) @(posedge clk);
        #1;
        check("idle_ready", {255'd0, ready}, 256'd0);

        // "abc" vector with exact latency
        pulse_start(c_blk_abc);
        check("abc_ready_after_start", {255'd0, ready}, 256'd0);
        finish_block("abc", c_dig_abc);

        // Result held in DONE
        repeat (5) @(posedge clk);
        #1;
        check("abc_hold_ready", {255'd0, ready}, 256'd1);
        check("abc_hold_hash", hash_out, c_dig_abc);

        // Empty message, started from DONE: ready drops, old digest held
        pulse_start(c_blk_empty);
        check("empty_ready_drop", {255'd0, ready}, 256'd0);
        check("empty_old_hash_held", hash_out, c_dig_abc);
        finish_block("empty", c_dig_empty);

        // Back to "abc": no chaining from the previous block
        pulse_start(c_blk_abc);
        check("abc2_ready_drop", {255'd0, ready}, 256'd0);
        finish_block("abc2", c_dig_abc);

        // Start during ROUND is ignored
        pulse_start(c_blk_abc);
        repeat (19) @(posedge clk);
        @(negedge clk);
        block_in = c_blk_empty;
        start    = 1'b1;
        @(posedge clk);   // edge N+20
        #1;
        start    = 1'b0;
        block_in = '0;
        check("ign_ready_low", {255'd0, ready}, 256'd0);
        repeat (44) @(posedge clk);   // through edge N+64
        #1;
        check("ign_ready_at_64", {255'd0, ready}, 256'd0);
        @(posedge clk);   // edge N+65
        #1;
        check("ign_ready_at_65", {255'd0, ready}, 256'd1);
        check("ign_digest", hash_out, c_dig_abc);

        // Reset mid-ROUND aborts and clears outputs
        pulse_start(c_blk_abc);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", {255'd0, ready}, 256'd0);
        check("abort_hash", hash_out, 256'd0);
        repeat (70) @(posedge clk);
        #1;
        check("abort_stays_idle", {255'd0, ready}, 256'd0);
        pulse_start(c_blk_abc);
        finish_block("post_abort", c_dig_abc);

        // start and rst on the same edge: reset wins
        @(negedge clk);
        block_in = c_blk_empty;
        start    = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        rst      = 1'b0;
        block_in = '0;
        check("rst_wins_hash", hash_out, 256'd0);
        repeat (70) @(posedge clk);
        #1;
        check("rst_wins_no_run", {255'd0, ready}, 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
